// File: rtl/gb_bustree_top.sv
// Ghostbus target tree: flat host bus decoded into top CSRs and four foo/bar leaves.
// Optional read-only ID register at 0x00F when GHOSTBUS_BUSTREE_ID_EN is defined.

module gb_bustree_leaf #(
    parameter bit          IS_FOO   = 1'b1,
    parameter logic [31:0] RAM_BASE = 32'h0000_0002
) (
    input  logic        gb_clk,
    input  logic        gb_rstb,
    input  logic        sel,
    input  logic [7:0]  off,
    input  logic [31:0] wdata,
    input  logic        wen,
    output logic [31:0] rdata
);
    localparam logic [15:0] CSR0_INIT = IS_FOO ? 16'h005A : 16'h1234;
    localparam logic [15:0] CSR0_MASK = IS_FOO ? 16'h00FF : 16'hFFFF;

    // NOTE: RAM has no reset; power-up content comes from the declaration initialiser only.
    logic [31:0] mem [16] = '{
        RAM_BASE + 32'd0,  RAM_BASE + 32'd1,  RAM_BASE + 32'd2,  RAM_BASE + 32'd3,
        RAM_BASE + 32'd4,  RAM_BASE + 32'd5,  RAM_BASE + 32'd6,  RAM_BASE + 32'd7,
        RAM_BASE + 32'd8,  RAM_BASE + 32'd9,  RAM_BASE + 32'd10, RAM_BASE + 32'd11,
        RAM_BASE + 32'd12, RAM_BASE + 32'd13, RAM_BASE + 32'd14, RAM_BASE + 32'd15
    };

    logic [15:0] csr0;
    logic [31:0] csr1;
    logic        ram_hit;
    logic        csr0_hit;
    logic        csr1_hit;

    assign ram_hit  = sel && (off[7:4] == 4'h1);
    assign csr0_hit = sel && (off == 8'h00);
    assign csr1_hit = sel && (off == 8'h01) && IS_FOO;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge gb_clk) begin
        if (!gb_rstb) begin
            csr0 <= CSR0_INIT;
            csr1 <= '0;
        end else if (wen) begin
            if (csr0_hit) csr0 <= wdata[15:0] & CSR0_MASK;
            if (csr1_hit) csr1 <= wdata;
        end
    end

    // RAM writes are independent of reset.
    always_ff @(posedge gb_clk) begin
        if (wen && ram_hit) mem[off[3:0]] <= wdata;
    end

    // NOTE: default assignment first keeps this combinational mux latch-free.
    always_comb begin
        rdata = '0;
        if (ram_hit)       rdata = mem[off[3:0]];
        else if (csr0_hit) rdata = {16'h0000, csr0};
        else if (csr1_hit) rdata = csr1;
    end
endmodule

module gb_bustree_top #(
    parameter int GB_AW = 24,
    parameter int GB_DW = 32
) (
    input  logic             gb_clk,
    input  logic             gb_rstb,
    input  logic [GB_AW-1:0] gb_addr,
    input  logic [GB_DW-1:0] gb_wdata,
    output logic [GB_DW-1:0] gb_rdata,
    input  logic             gb_wen
);
    logic             hi_ok;
    logic [11:0]      addr_lo;
    logic [GB_DW-1:0] top_ctrl;
    logic [GB_DW-1:0] top_scratch;
    logic             ctrl_hit;
    logic             scratch_hit;
    logic [GB_DW-1:0] leaf_rdata [4];
    logic [GB_DW-1:0] rd_next;

    if (GB_AW > 12) begin : g_hi
        assign hi_ok = ~|gb_addr[GB_AW-1:12];
    end else begin : g_nohi
        assign hi_ok = 1'b1;
    end

    assign addr_lo     = gb_addr[11:0];
    assign ctrl_hit    = hi_ok && (addr_lo == 12'h000);
    assign scratch_hit = hi_ok && (addr_lo == 12'h001);

    always_ff @(posedge gb_clk) begin
        if (!gb_rstb) begin
            top_ctrl    <= '0;
            top_scratch <= 32'hDEAD_BEEF;
        end else if (gb_wen) begin
            if (ctrl_hit)    top_ctrl    <= gb_wdata;
            if (scratch_hit) top_scratch <= gb_wdata;
        end
    end

    // Leaves at pages 1..4 alternate foo/bar; an unselected leaf drives zero.
    for (genvar g = 0; g < 4; g++) begin : g_leaf
        gb_bustree_leaf #(
            .IS_FOO   ((g % 2) == 0),
            .RAM_BASE (((g % 2) == 0) ? 32'h0000_0002 : 32'h0000_0081)
        ) u_leaf (
            .gb_clk  (gb_clk),
            .gb_rstb (gb_rstb),
            .sel     (hi_ok && (addr_lo[11:8] == 4'(g + 1))),
            .off     (addr_lo[7:0]),
            .wdata   (gb_wdata),
            .wen     (gb_wen),
            .rdata   (leaf_rdata[g])
        );
    end

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < 4; i++) rd_next = rd_next | leaf_rdata[i];
        if (ctrl_hit)    rd_next = top_ctrl;
        if (scratch_hit) rd_next = top_scratch;
`ifdef GHOSTBUS_BUSTREE_ID_EN
        if (hi_ok && (addr_lo == 12'h00F)) rd_next = 32'h4742_5431;
`endif
    end

    always_ff @(posedge gb_clk) begin
        if (!gb_rstb) gb_rdata <= '0;
        else          gb_rdata <= rd_next;
    end
endmodule

// File: tb/tb_gb_bustree_top.sv
// Self-checking bench for gb_bustree_top: directed vector table, reset sequences,
// then randomized traffic against an address-map model.

module tb_gb_bustree_top;
    localparam int AW = 24;
`ifdef GHOSTBUS_BUSTREE_ID_EN
    localparam logic [31:0] TB_ID = 32'h4742_5431;
`else
    localparam logic [31:0] TB_ID = 32'h0000_0000;
`endif

    logic          gb_clk = 1'b0;
    logic          gb_rstb = 1'b0;
    logic [AW-1:0] gb_addr = '0;
    logic [31:0]   gb_wdata = '0;
    logic [31:0]   gb_rdata;
    logic          gb_wen = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    gb_bustree_top #(.GB_AW(AW), .GB_DW(32)) dut (
        .gb_clk   (gb_clk),
        .gb_rstb  (gb_rstb),
        .gb_addr  (gb_addr),
        .gb_wdata (gb_wdata),
        .gb_rdata (gb_rdata),
        .gb_wen   (gb_wen)
    );

    always #5 gb_clk = ~gb_clk;

    // Address-map model: one entry per mapped storage word.
    logic [31:0] model_mem [logic [AW-1:0]];

    function automatic logic [31:0] model_mask(input logic [AW-1:0] a);
        int page;
        int off;
        page = int'(a >> 8);
        off  = int'(a & 24'hFF);
        if (a == 0 || a == 1) return 32'hFFFF_FFFF;
        if (page < 1 || page > 4) return 32'h0;
        if (off >= 16 && off < 32) return 32'hFFFF_FFFF;
        if (off == 0) return (page % 2 == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        if (off == 1 && page % 2 == 1) return 32'hFFFF_FFFF;
        return 32'h0;
    endfunction

    function automatic bit model_is_ram(input logic [AW-1:0] a);
        int page;
        page = int'(a >> 8);
        return (page >= 1) && (page <= 4) && (a[7:4] == 4'h1);
    endfunction

    function automatic logic [31:0] model_read(input logic [AW-1:0] a);
        if (a == 24'h00F) return TB_ID;
        if (model_mask(a) == 0) return 32'h0;
        return model_mem[a];
    endfunction

    task automatic model_power_up();
        for (int k = 1; k <= 4; k++)
            for (int i = 0; i < 16; i++)
                model_mem[AW'(k * 256 + 16 + i)] = ((k % 2 == 1) ? 32'h2 : 32'h81) + 32'(i);
    endtask

    task automatic model_reset();
        model_mem[0] = 32'h0;
        model_mem[1] = 32'hDEAD_BEEF;
        for (int k = 1; k <= 4; k++) begin
            model_mem[AW'(k * 256)] = (k % 2 == 1) ? 32'h5A : 32'h1234;
            if (k % 2 == 1) model_mem[AW'(k * 256 + 1)] = 32'h0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // One bus cycle: apply inputs, clock once, sample after the edge, update the model.
    task automatic drive(input logic [AW-1:0] a, input logic [31:0] d, input logic w, input logic rst);
        gb_addr  = a;
        gb_wdata = d;
        gb_wen   = w;
        gb_rstb  = ~rst;
        @(posedge gb_clk);
        #1;
        if (rst) model_reset();
        if (w && model_mask(a) != 0 && (!rst || model_is_ram(a)))
            model_mem[a] = d & model_mask(a);
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic          wen;
        logic [31:0]   exp;
        string         name;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        model_power_up();
        model_reset();

        drive(24'h0, 32'h0, 1'b0, 1'b1);
        check("rst_rdata", gb_rdata, 32'h0);
        drive(24'h0, 32'h0, 1'b0, 1'b1);

        tbl.push_back('{24'h000000, 32'h0, 1'b0, 32'h0000_0000, "top_ctrl_init"});
        tbl.push_back('{24'h000001, 32'h0, 1'b0, 32'hDEAD_BEEF, "top_scratch_init"});
        tbl.push_back('{24'h000100, 32'h0, 1'b0, 32'h0000_005A, "bfoo_ctl_init"});
        tbl.push_back('{24'h000101, 32'h0, 1'b0, 32'h0000_0000, "bfoo_cnt_init"});
        tbl.push_back('{24'h000200, 32'h0, 1'b0, 32'h0000_1234, "bbar_cfg_init"});
        tbl.push_back('{24'h000300, 32'h0, 1'b0, 32'h0000_005A, "tfoo_ctl_init"});
        tbl.push_back('{24'h000301, 32'h0, 1'b0, 32'h0000_0000, "tfoo_cnt_init"});
        tbl.push_back('{24'h000400, 32'h0, 1'b0, 32'h0000_1234, "tbar_cfg_init"});
        tbl.push_back('{24'h000110, 32'h0, 1'b0, 32'h0000_0002, "ram_110"});
        tbl.push_back('{24'h000111, 32'h0, 1'b0, 32'h0000_0003, "ram_111"});
        tbl.push_back('{24'h000210, 32'h0, 1'b0, 32'h0000_0081, "ram_210"});
        tbl.push_back('{24'h000211, 32'h0, 1'b0, 32'h0000_0082, "ram_211"});
        tbl.push_back('{24'h000310, 32'h0, 1'b0, 32'h0000_0002, "ram_310"});
        tbl.push_back('{24'h000311, 32'h0, 1'b0, 32'h0000_0003, "ram_311"});
        tbl.push_back('{24'h000410, 32'h0, 1'b0, 32'h0000_0081, "ram_410"});
        tbl.push_back('{24'h000411, 32'h0, 1'b0, 32'h0000_0082, "ram_411"});
        tbl.push_back('{24'h00000F, 32'h0, 1'b0, TB_ID,         "id_read"});
        tbl.push_back('{24'h00000F, 32'h1, 1'b1, TB_ID,         "id_write"});
        tbl.push_back('{24'h00000F, 32'h0, 1'b0, TB_ID,         "id_after_write"});
        tbl.push_back('{24'h000200, 32'hFFFF_FFFF, 1'b1, 32'h0000_1234, "bar_cfg_wr_old"});
        tbl.push_back('{24'h000200, 32'h0, 1'b0, 32'h0000_FFFF, "bar_cfg_masked"});
        tbl.push_back('{24'h000300, 32'hFFFF_FF33, 1'b1, 32'h0000_005A, "foo_ctl_wr_old"});
        tbl.push_back('{24'h000300, 32'h0, 1'b0, 32'h0000_0033, "foo_ctl_masked"});
        tbl.push_back('{24'h000001, 32'h0000_A5A5, 1'b1, 32'hDEAD_BEEF, "scratch_wr_old"});
        tbl.push_back('{24'h000001, 32'h0, 1'b0, 32'h0000_A5A5, "scratch_new"});
        tbl.push_back('{24'h00031F, 32'hCAFE_F00D, 1'b1, 32'h0000_0011, "ram_31f_wr_old"});
        tbl.push_back('{24'h00031F, 32'h0, 1'b0, 32'hCAFE_F00D, "ram_31f_new"});
        tbl.push_back('{24'h00011F, 32'h0, 1'b0, 32'h0000_0011, "ram_11f_no_alias"});
        tbl.push_back('{24'h000105, 32'h1234_5678, 1'b1, 32'h0, "unmap_105_wr"});
        tbl.push_back('{24'h001100, 32'h1234_5678, 1'b1, 32'h0, "unmap_1100_wr"});
        tbl.push_back('{24'h000105, 32'h0, 1'b0, 32'h0, "unmap_105_rd"});
        tbl.push_back('{24'h001100, 32'h0, 1'b0, 32'h0, "unmap_1100_rd"});
        tbl.push_back('{24'h000100, 32'h0, 1'b0, 32'h0000_005A, "foo_ctl_no_alias"});

        foreach (tbl[i]) begin
            drive(tbl[i].addr, tbl[i].wdata, tbl[i].wen, 1'b0);
            check(tbl[i].name, gb_rdata, tbl[i].exp);
        end

        // CSR reset with RAM retention.
        drive(24'h000100, 32'h11, 1'b1, 1'b0);
        drive(24'h000110, 32'h77, 1'b1, 1'b0);
        drive(24'h000100, 32'h0, 1'b0, 1'b1);
        check("rdata_in_reset", gb_rdata, 32'h0);
        drive(24'h000100, 32'h0, 1'b0, 1'b0);
        check("foo_ctl_after_rst", gb_rdata, 32'h5A);
        drive(24'h000110, 32'h0, 1'b0, 1'b0);
        check("ram_kept_after_rst", gb_rdata, 32'h77);

        // Writes concurrent with reset: RAM lands, CSR is dropped.
        drive(24'h000411, 32'h99, 1'b1, 1'b1);
        drive(24'h000001, 32'h55, 1'b1, 1'b1);
        check("rdata_in_reset2", gb_rdata, 32'h0);
        drive(24'h000411, 32'h0, 1'b0, 1'b0);
        check("ram_wr_during_rst", gb_rdata, 32'h99);
        drive(24'h000001, 32'h0, 1'b0, 1'b0);
        check("csr_wr_dropped_rst", gb_rdata, 32'hDEAD_BEEF);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [AW-1:0] a;
            logic [31:0]   d;
            logic          w;
            logic          r;
            logic [31:0]   exp;
            int            k;
            k = $urandom_range(1, 4);
            case ($urandom_range(0, 6))
                0: a = AW'($urandom_range(0, 1));
                1: a = 24'h00F;
                2: a = AW'(k * 256 + $urandom_range(0, 1));
                3: a = AW'(k * 256 + 16 + $urandom_range(0, 15));
                4: a = AW'(k * 256 + $urandom_range(2, 255));
                5: a = AW'($urandom_range(0, 32'h00FF_FFFF));
                default: a = AW'(k * 256 + 16 + $urandom_range(0, 15));
            endcase
            d   = $urandom;
            w   = 1'($urandom_range(0, 1));
            r   = ($urandom_range(0, 63) == 0);
            exp = r ? 32'h0 : model_read(a);
            drive(a, d, w, r);
            check($sformatf("rand_%0d_a%06h", n, a), gb_rdata, exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
